// File: rtl/breadboard_sweep_ctrl.sv
// Sweeps the 4-input Breadboard block through all 16 codes, captures each 10-bit
// result onto a valid/ready stream and folds it into a rotating 16-bit signature.
module breadboard_sweep_ctrl #(
    parameter int unsigned SETTLE   = 4,
    parameter logic [15:0] SIG_SEED = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    output logic        w_o,
    output logic        x_o,
    output logic        y_o,
    output logic        z_o,
    input  logic [9:0]  r_i,
    output logic        vec_valid_o,
    input  logic        vec_ready_i,
    output logic [3:0]  vec_idx_o,
    output logic [9:0]  vec_r_o,
    output logic        grp_end_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] sig_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE - 1);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  drv_q, drv_d;
    logic [3:0]  vec_idx_q, vec_idx_d;
    logic [9:0]  vec_r_q, vec_r_d;
    logic [15:0] sig_q, sig_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= 4'd0;
            cnt_q     <= 8'd0;
            drv_q     <= 4'd0;
            vec_idx_q <= 4'd0;
            vec_r_q   <= 10'd0;
            sig_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            drv_q     <= drv_d;
            vec_idx_q <= vec_idx_d;
            vec_r_q   <= vec_r_d;
            sig_q     <= sig_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        drv_d     = drv_q;
        vec_idx_d = vec_idx_q;
        vec_r_d   = vec_r_q;
        sig_d     = sig_q;

        // Abort dominates everything, including a coincident start.
        if (abort_i) begin
            state_d = S_IDLE;
            drv_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        idx_d   = 4'd0;
                        cnt_d   = CNT_LOAD;
                        sig_d   = SIG_SEED;
                        drv_d   = 4'd0;
                        state_d = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        vec_r_d   = r_i;
                        vec_idx_d = idx_q;
                        sig_d     = {sig_q[14:0], sig_q[15]} ^ {6'b0, r_i};
                        state_d   = S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (vec_ready_i) begin
                        // Sweep ends at code 15; the drive stays at 4'hF in DONE.
                        if (idx_q == 4'hF) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            drv_d   = idx_q + 4'd1;
                            cnt_d   = CNT_LOAD;
                            state_d = S_SETTLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign {w_o, x_o, y_o, z_o} = drv_q;
    assign vec_valid_o = (state_q == S_PRESENT);
    assign busy_o      = (state_q == S_SETTLE) || (state_q == S_PRESENT);
    assign done_o      = (state_q == S_DONE);
    assign vec_idx_o   = vec_idx_q;
    assign vec_r_o     = vec_r_q;
    assign grp_end_o   = vec_valid_o && (vec_idx_q[1:0] == 2'b11);
    assign sig_o       = sig_q;

endmodule

// File: tb/tb_breadboard_sweep_ctrl.sv
// Directed bench for breadboard_sweep_ctrl: a SETTLE=4 instance driven by a
// table-based Breadboard model (or a zero stub) and a SETTLE=1 instance.
module tb_breadboard_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [9:0] rom [16];
    logic       stub;

    // instance A: SETTLE=4, seed A5C3
    logic        start_a, abort_a, ready_a;
    logic        wa, xa, ya, za;
    logic [9:0]  r_a;
    logic        valid_a, grp_a, busy_a, done_a;
    logic [3:0]  idx_a;
    logic [9:0]  vr_a;
    logic [15:0] sig_a;
    assign r_a = stub ? 10'h000 : rom[{wa, xa, ya, za}];

    // instance B: SETTLE=1, seed 1234
    logic        start_b, abort_b, ready_b;
    logic        wb, xb, yb, zb;
    logic [9:0]  r_b;
    logic        valid_b, grp_b, busy_b, done_b;
    logic [3:0]  idx_b;
    logic [9:0]  vr_b;
    logic [15:0] sig_b;
    assign r_b = rom[{wb, xb, yb, zb}];

    breadboard_sweep_ctrl #(.SETTLE(4), .SIG_SEED(16'hA5C3)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .abort_i(abort_a),
        .w_o(wa), .x_o(xa), .y_o(ya), .z_o(za), .r_i(r_a),
        .vec_valid_o(valid_a), .vec_ready_i(ready_a), .vec_idx_o(idx_a),
        .vec_r_o(vr_a), .grp_end_o(grp_a), .busy_o(busy_a), .done_o(done_a),
        .sig_o(sig_a)
    );

    breadboard_sweep_ctrl #(.SETTLE(1), .SIG_SEED(16'h1234)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .abort_i(abort_b),
        .w_o(wb), .x_o(xb), .y_o(yb), .z_o(zb), .r_i(r_b),
        .vec_valid_o(valid_b), .vec_ready_i(ready_b), .vec_idx_o(idx_b),
        .vec_r_o(vr_b), .grp_end_o(grp_b), .busy_o(busy_b), .done_o(done_b),
        .sig_o(sig_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sig_model(input logic [15:0] seed, input bit zero);
        logic [15:0] s;
        s = seed;
        for (int i = 0; i < 16; i++)
            s = {s[14:0], s[15]} ^ {6'b0, (zero ? 10'h000 : rom[i])};
        return s;
    endfunction

    // One full sweep on instance A with optional backpressure of bp_len cycles at bp_idx.
    task automatic run_a(input int bp_idx, input int bp_len, output int cyc);
        int nexp;
        int held;
        logic [9:0] er;
        nexp = 0;
        held = 0;
        @(negedge clk);
        start_a = 1'b1;
        ready_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        cyc = 0;
        while (cyc < 400) begin
            @(negedge clk);
            if (held > 0 && held < bp_len) begin
                chk("bp_valid", 32'(valid_a), 32'd1);
                chk("bp_idx", 32'(idx_a), 32'(bp_idx));
                chk("bp_r", 32'(vr_a), 32'(rom[bp_idx]));
                chk("bp_wxyz", 32'({wa, xa, ya, za}), 32'(bp_idx));
                ready_a = 1'b0;
                held++;
            end else if (held == 0 && bp_len > 0 && valid_a && idx_a == 4'(bp_idx)) begin
                ready_a = 1'b0;
                held = 1;
            end else begin
                ready_a = 1'b1;
            end
            if (valid_a && ready_a) begin
                er = stub ? 10'h000 : rom[nexp];
                chk("hs_idx", 32'(idx_a), 32'(nexp));
                chk("hs_r", 32'(vr_a), 32'(er));
                chk("hs_wxyz", 32'({wa, xa, ya, za}), 32'(nexp));
                chk("grp_end", 32'(grp_a), 32'((nexp % 4) == 3));
                nexp++;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (done_a) break;
        end
        chk("nvec", 32'(nexp), 32'd16);
    endtask

    initial begin
        int cyc;
        int k;
        int n;
        bit seen;
        logic [15:0] sig_hold;

        rom[0]  = 10'h020; rom[1]  = 10'h1A3; rom[2]  = 10'h0F4; rom[3]  = 10'h215;
        rom[4]  = 10'h3C6; rom[5]  = 10'h0C2; rom[6]  = 10'h088; rom[7]  = 10'h1F9;
        rom[8]  = 10'h22A; rom[9]  = 10'h05B; rom[10] = 10'h3E0; rom[11] = 10'h16D;
        rom[12] = 10'h2BE; rom[13] = 10'h09F; rom[14] = 10'h301; rom[15] = 10'h11F;

        stub = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b1;
        start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_wxyz", 32'({wa, xa, ya, za}), 32'd0);
        chk("rst_idx", 32'(idx_a), 32'd0);
        chk("rst_r", 32'(vr_a), 32'd0);
        chk("rst_sig", 32'(sig_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // T1: real table, full-rate sink
        run_a(-1, 0, cyc);
        chk("t1_cycles", 32'(cyc), 32'd80);
        chk("t1_sig", 32'(sig_a), 32'(sig_model(16'hA5C3, 1'b0)));
        chk("t1_wxyz", 32'({wa, xa, ya, za}), 32'hF);
        chk("t1_busy", 32'(busy_a), 32'd0);
        chk("t1_done", 32'(done_a), 32'd1);
        repeat (3) @(posedge clk);
        #1 chk("t1_sig_hold", 32'(sig_a), 32'(sig_model(16'hA5C3, 1'b0)));

        // T2: zero stub, signature is 16 pure rotations of the seed
        stub = 1'b1;
        run_a(-1, 0, cyc);
        chk("t2_cycles", 32'(cyc), 32'd80);
        chk("t2_sig", 32'(sig_a), 32'hA5C3);
        stub = 1'b0;

        // T3: 7 cycles of backpressure at idx 6
        run_a(6, 7, cyc);
        chk("t3_cycles", 32'(cyc), 32'd87);
        chk("t3_sig", 32'(sig_a), 32'(sig_model(16'hA5C3, 1'b0)));

        // T4: abort in SETTLE of idx 9, then start+abort together, then restart
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        k = 0;
        while (!({wa, xa, ya, za} == 4'd9 && busy_a && !valid_a) && k < 200) begin
            @(posedge clk);
            #1 k++;
        end
        chk("t4_reach9", 32'(k < 200), 32'd1);
        sig_hold = sig_a;
        abort_a = 1'b1;
        @(posedge clk);
        #1 abort_a = 1'b0;
        chk("t4_busy", 32'(busy_a), 32'd0);
        chk("t4_done", 32'(done_a), 32'd0);
        chk("t4_valid", 32'(valid_a), 32'd0);
        chk("t4_wxyz", 32'({wa, xa, ya, za}), 32'd0);
        chk("t4_sig", 32'(sig_a), 32'(sig_hold));
        start_a = 1'b1;
        abort_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        abort_a = 1'b0;
        chk("t4_abort_wins", 32'(busy_a), 32'd0);
        run_a(-1, 0, cyc);
        chk("t4_cycles", 32'(cyc), 32'd80);

        // T5: start while busy ignored, then async reset in PRESENT of idx 12
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        k = 0;
        while ({wa, xa, ya, za} != 4'd3 && k < 200) begin
            @(posedge clk);
            #1 k++;
        end
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        seen = 1'b0;
        k = 0;
        while (!(valid_a && idx_a == 4'd12) && k < 200) begin
            if (valid_a && !seen) begin
                chk("t5_ignore_start", 32'(idx_a), 32'd3);
                seen = 1'b1;
            end
            @(posedge clk);
            #1 k++;
        end
        chk("t5_reach12", 32'(k < 200), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_valid", 32'(valid_a), 32'd0);
        chk("t5_busy", 32'(busy_a), 32'd0);
        chk("t5_done", 32'(done_a), 32'd0);
        chk("t5_wxyz", 32'({wa, xa, ya, za}), 32'd0);
        chk("t5_idx", 32'(idx_a), 32'd0);
        chk("t5_r", 32'(vr_a), 32'd0);
        chk("t5_sig", 32'(sig_a), 32'd0);
        chk("t5_grp", 32'(grp_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // T6: SETTLE=1 instance, two vectors per ... 2 cycles each, then re-run from DONE
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            start_b = 1'b1;
            @(posedge clk);
            #1 start_b = 1'b0;
            chk("t6_seed", 32'(sig_b), 32'h1234);
            chk("t6_busy", 32'(busy_b), 32'd1);
            chk("t6_done_clr", 32'(done_b), 32'd0);
            k = 0;
            n = 0;
            while (k < 200) begin
                @(posedge clk);
                #1 k++;
                if (valid_b) begin
                    if (n == 0 || n == 7 || n == 15)
                        chk("t6_slot", 32'(k), 32'(2 * n + 1));
                    n++;
                end
                if (done_b) break;
            end
            chk("t6_cycles", 32'(k), 32'd32);
            chk("t6_nvec", 32'(n), 32'd16);
            chk("t6_sig", 32'(sig_b), 32'(sig_model(16'h1234, 1'b0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
